// File: rtl/demux_bus_credit_scheduler.sv
// Credit-based round-robin dispatcher in front of a one-hot bus demux.
// One input beat per cycle is steered to the first eligible lane at or after
// the round-robin pointer. Per-lane credit counters mirror downstream buffer
// space; a flush request drains every enabled lane back to full credit before
// signalling completion.
//
// Handshake: a beat transfers on a cycle where data_in_valid and data_in_ready
// are both high at the rising edge of ap_clk. data_in_ready depends only on
// registered state, never on data_in_valid. Outputs toward the demux carry no
// back-pressure.
module demux_bus_credit_scheduler #(
  parameter int DATA_WIDTH   = 32,
  parameter int BUS_WIDTH    = 8,
  parameter int CREDIT_DEPTH = 4,
  parameter int CREDIT_WIDTH = $clog2(CREDIT_DEPTH + 1)
) (
  input  logic                  ap_clk,
  input  logic                  areset,
  input  logic [BUS_WIDTH-1:0]  lane_enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  input  logic [BUS_WIDTH-1:0]  credit_return,
  input  logic                  flush_in,
  output logic [BUS_WIDTH-1:0]  sel_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [BUS_WIDTH-1:0]  data_out_valid,
  output logic                  flush_done,
  output logic                  credit_overflow,
  output logic [1:0]            dbg_state
);

  localparam int PTR_W = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_FULL = CREDIT_WIDTH'(CREDIT_DEPTH);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CREDIT_WIDTH-1:0] credit_q [BUS_WIDTH];
  logic [CREDIT_WIDTH-1:0] credit_d [BUS_WIDTH];
  logic [BUS_WIDTH-1:0]    sel_q, sel_d;
  logic [BUS_WIDTH-1:0]    dv_q, dv_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    ovf_q, ovf_d;

  logic [BUS_WIDTH-1:0]    eligible;
  logic [2*BUS_WIDTH-1:0]  eligible_x2;
  logic [BUS_WIDTH-1:0]    rotated;
  logic [BUS_WIDTH-1:0]    grant;
  logic [PTR_W-1:0]        grant_idx;
  logic                    any_eligible;
  logic                    accept;
  logic                    drained;
  logic                    consume_at_zero;

  // Lane eligibility: enabled and holding at least one credit.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < BUS_WIDTH; i++) begin
      eligible[i] = lane_enable[i] && (credit_q[i] != '0);
    end
  end

  assign any_eligible  = |eligible;
  assign data_in_ready = (state_q == S_RUN) && any_eligible;
  assign accept        = data_in_valid && data_in_ready;

  // Round-robin pick: rotate eligibility so the pointer lane sits at bit 0,
  // take the lowest set bit, then map back to an absolute lane index.
  assign eligible_x2 = {eligible, eligible};
  assign rotated     = eligible_x2[rr_ptr_q +: BUS_WIDTH];

  always_comb begin
    logic found;
    int   idx;
    found     = 1'b0;
    idx       = 0;
    grant_idx = '0;
    for (int k = 0; k < BUS_WIDTH; k++) begin
      if (!found && rotated[k]) begin
        found = 1'b1;
        idx   = int'(rr_ptr_q) + k;
        if (idx >= BUS_WIDTH) idx = idx - BUS_WIDTH;
        grant_idx = PTR_W'(idx);
      end
    end
    grant = found ? (BUS_WIDTH'(1) << grant_idx) : '0;
  end

  // Drain is complete when every enabled lane is back to full credit and no
  // beat is still on its way out.
  always_comb begin
    drained = ~|dv_q;
    for (int i = 0; i < BUS_WIDTH; i++) begin
      if (lane_enable[i] && (credit_q[i] != CREDIT_FULL)) drained = 1'b0;
    end
  end

  // FSM next-state: run -> drain on flush, drain -> done once empty, done -> run.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN:   if (flush_in) state_d = S_DRAIN;
      S_DRAIN: if (drained)  state_d = S_DONE;
      S_DONE:  state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  // Output datapath and pointer: load on accept, pointer restarts after a flush.
  always_comb begin
    sel_d    = sel_q;
    data_d   = data_q;
    dv_d     = '0;
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      sel_d    = grant;
      dv_d     = grant;
      data_d   = data_in;
      rr_ptr_d = (int'(grant_idx) == BUS_WIDTH - 1) ? '0 : grant_idx + 1'b1;
    end
    if (state_q == S_DONE) rr_ptr_d = '0;
  end

  // Credit bookkeeping: return adds, consume subtracts, both cancel out.
  // A return to a full counter saturates and raises the sticky overflow flag.
  always_comb begin
    logic consume;
    consume         = 1'b0;
    ovf_d           = ovf_q;
    consume_at_zero = 1'b0;
    for (int i = 0; i < BUS_WIDTH; i++) begin
      credit_d[i] = credit_q[i];
      consume     = accept && grant[i];
      if (consume && (credit_q[i] == '0)) consume_at_zero = 1'b1;
      if (credit_return[i] && !consume) begin
        if (credit_q[i] == CREDIT_FULL) ovf_d = 1'b1;
        else                            credit_d[i] = credit_q[i] + 1'b1;
      end else if (!credit_return[i] && consume) begin
        credit_d[i] = credit_q[i] - 1'b1;
      end
    end
  end

  // State registers with synchronous reset; reset discards any drain in flight.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state_q  <= S_RUN;
      rr_ptr_q <= '0;
      sel_q    <= '0;
      dv_q     <= '0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < BUS_WIDTH; i++) credit_q[i] <= CREDIT_FULL;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      sel_q    <= sel_d;
      dv_q     <= dv_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
      for (int i = 0; i < BUS_WIDTH; i++) credit_q[i] <= credit_d[i];
    end
  end

  assign sel_out         = sel_q;
  assign data_out        = data_q;
  assign data_out_valid  = dv_q;
  assign flush_done      = (state_q == S_DONE);
  assign credit_overflow = ovf_q;
  assign dbg_state       = state_q;

  // The grant logic only picks lanes with credit, so this must never fire.
  a_no_consume_at_zero: assert property (@(posedge ap_clk) disable iff (areset)
    !consume_at_zero);

endmodule

// File: tb/tb_demux_bus_credit_scheduler.sv
// Bench for demux_bus_credit_scheduler with 4 lanes and 2 credits per lane.
// A lane-level model tracks credits, pointer and flush phase with plain
// integers and is compared against the DUT on every falling edge; directed
// sequences add literal expectations for the documented scenarios.
module tb_demux_bus_credit_scheduler;

  localparam int N = 4;
  localparam int D = 2;
  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          areset;
  logic [N-1:0]  lane_enable;
  logic [W-1:0]  data_in;
  logic          data_in_valid;
  logic          data_in_ready;
  logic [N-1:0]  credit_return;
  logic          flush_in;
  logic [N-1:0]  sel_out;
  logic [W-1:0]  data_out;
  logic [N-1:0]  data_out_valid;
  logic          flush_done;
  logic          credit_overflow;
  logic [1:0]    dbg_state;

  demux_bus_credit_scheduler #(
    .DATA_WIDTH(W), .BUS_WIDTH(N), .CREDIT_DEPTH(D)
  ) dut (
    .ap_clk(clk), .areset(areset), .lane_enable(lane_enable),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .credit_return(credit_return), .flush_in(flush_in),
    .sel_out(sel_out), .data_out(data_out), .data_out_valid(data_out_valid),
    .flush_done(flush_done), .credit_overflow(credit_overflow), .dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_phase: 0 = dispatching, 1 = draining, 2 = flush complete cycle
  int           m_cred [N];
  int           m_rr;
  int           m_phase;
  logic [N-1:0] m_sel, m_dv;
  logic [W-1:0] m_data;
  bit           m_ovf;
  logic [W-1:0] exp_q [$];

  function automatic bit m_ready();
    if (m_phase != 0) return 1'b0;
    for (int i = 0; i < N; i++) if (lane_enable[i] && m_cred[i] > 0) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin : model
    bit acc;
    bit empty;
    int lane;
    int j;
    int c;
    if (areset) begin
      for (int i = 0; i < N; i++) m_cred[i] = D;
      m_rr = 0; m_phase = 0; m_sel = '0; m_dv = '0; m_data = '0; m_ovf = 1'b0;
      exp_q.delete();
    end else begin
      acc  = data_in_valid && m_ready();
      lane = -1;
      if (acc) begin
        for (int k = 0; k < N; k++) begin
          j = (m_rr + k) % N;
          if (lane < 0 && lane_enable[j] && m_cred[j] > 0) lane = j;
        end
      end
      empty = (m_dv == 0);
      for (int i = 0; i < N; i++) if (lane_enable[i] && m_cred[i] != D) empty = 1'b0;
      for (int i = 0; i < N; i++) begin
        c = m_cred[i] + int'(credit_return[i]) - ((acc && lane == i) ? 1 : 0);
        if (c > D) begin c = D; m_ovf = 1'b1; end
        m_cred[i] = c;
      end
      m_dv = '0;
      if (acc) begin
        m_dv   = N'(1) << lane;
        m_sel  = m_dv;
        m_data = data_in;
        exp_q.push_back(data_in);
        m_rr   = (lane + 1) % N;
      end
      case (m_phase)
        0: if (flush_in) m_phase = 1;
        1: if (empty) m_phase = 2;
        default: begin m_phase = 0; m_rr = 0; end
      endcase
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      chk("ready", data_in_ready, m_ready());
      chk("sel", sel_out, m_sel);
      chk("dv", data_out_valid, m_dv);
      chk("data", data_out, m_data);
      chk("flush_done", flush_done, (m_phase == 2));
      chk("overflow", credit_overflow, m_ovf);
      if (data_out_valid != '0) begin
        if (exp_q.size() == 0) chk("sb_empty", 1, 0);
        else chk("sb_data", data_out, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [N-1:0] en);
    areset = 1'b1; lane_enable = en; data_in_valid = 1'b0;
    credit_return = '0; flush_in = 1'b0; data_in = '0;
    tick(); chk_on = 1'b1; tick();
    areset = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] d);
    data_in = d; data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
  endtask

  task automatic pulse_return(input logic [N-1:0] r);
    credit_return = r;
    tick();
    credit_return = '0;
  endtask

  logic [N-1:0] rr_exp [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
  logic [N-1:0] skip_exp [6] = '{4'h1, 4'h2, 4'h8, 4'h1, 4'h2, 4'h8};

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- directed sequences ----------------
  initial begin
    areset = 1'b1; lane_enable = '1; data_in = '0; data_in_valid = 1'b0;
    credit_return = '0; flush_in = 1'b0;

    // Reset state then round-robin over all lanes until credits run out.
    do_reset(4'hF);
    chk("rst_ready", data_in_ready, 1);
    chk("rst_sel", sel_out, 0);
    chk("rst_dv", data_out_valid, 0);
    chk("rst_data", data_out, 0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_ovf", credit_overflow, 0);
    for (int k = 0; k < 8; k++) begin
      send(W'(16'hA0 + k));
      chk("rr_sel", sel_out, rr_exp[k]);
      chk("rr_data", data_out, 16'hA0 + k);
    end
    chk("rr_ready_low", data_in_ready, 0);
    tick();
    chk("rr_dv_idle", data_out_valid, 0);
    chk("rr_sel_hold", sel_out, 4'h8);

    // Skip disabled lane 2 and a lane with no credit.
    do_reset(4'b1011);
    for (int k = 0; k < 6; k++) begin
      send(W'(16'h40 + k));
      chk("skip_fill_sel", sel_out, skip_exp[k]);
    end
    chk("skip_ready_low", data_in_ready, 0);
    pulse_return(4'b1010);
    chk("skip_ready_back", data_in_ready, 1);
    send(16'h51);
    chk("skip_lane1", sel_out, 4'h2);
    send(16'h52);
    chk("skip_lane3", sel_out, 4'h8);
    chk("skip_ready_end", data_in_ready, 0);

    // Simultaneous return and consume on lane 2.
    do_reset(4'hF);
    for (int k = 0; k < 6; k++) send(W'(16'h60 + k));
    credit_return = 4'b0100;
    send(16'h70);
    credit_return = '0;
    chk("sim_sel", sel_out, 4'h4);
    chk("sim_ready", data_in_ready, 1);
    send(16'h71);
    chk("sim_next_lane3", sel_out, 4'h8);
    send(16'h72);
    chk("sim_lane2_kept", sel_out, 4'h4);
    chk("sim_ready_end", data_in_ready, 0);

    // Return to a full counter: saturate and latch overflow.
    do_reset(4'hF);
    pulse_return(4'b0001);
    chk("ovf_set", credit_overflow, 1);
    repeat (3) tick();
    chk("ovf_sticky", credit_overflow, 1);
    for (int k = 0; k < 8; k++) send(W'(16'h80 + k));
    chk("ovf_sat_ready", data_in_ready, 0);
    chk("ovf_still", credit_overflow, 1);
    do_reset(4'hF);
    chk("ovf_cleared", credit_overflow, 0);

    // Flush with three beats outstanding; third beat coincides with flush.
    send(16'hC0);
    send(16'hC1);
    data_in = 16'hC2; data_in_valid = 1'b1; flush_in = 1'b1;
    tick();
    data_in_valid = 1'b0; flush_in = 1'b0;
    chk("fl_last_beat", data_out_valid, 4'h4);
    chk("fl_ready_low", data_in_ready, 0);
    repeat (2) tick();
    pulse_return(4'b0001);
    repeat (3) tick();
    pulse_return(4'b0010);
    repeat (2) tick();
    chk("fl_not_yet", flush_done, 0);
    pulse_return(4'b0100);
    chk("fl_drain_cycle", flush_done, 0);
    tick();
    chk("fl_done_pulse", flush_done, 1);
    chk("fl_done_ready", data_in_ready, 0);
    tick();
    chk("fl_done_end", flush_done, 0);
    chk("fl_ready_back", data_in_ready, 1);
    send(16'hD0);
    chk("fl_ptr_reset", sel_out, 4'h1);

    // Reset during drain with credits outstanding.
    do_reset(4'hF);
    send(16'hE0);
    send(16'hE1);
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    tick();
    chk("rmd_draining", data_in_ready, 0);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    chk("rmd_sel", sel_out, 0);
    chk("rmd_dv", data_out_valid, 0);
    chk("rmd_data", data_out, 0);
    chk("rmd_ready", data_in_ready, 1);
    for (int k = 0; k < 3; k++) begin
      chk("rmd_no_done", flush_done, 0);
      tick();
    end
    for (int k = 0; k < 8; k++) send(W'(16'hF0 + k));
    chk("rmd_credits_full", data_in_ready, 0);

    // No enabled lanes: never ready, flush completes after one drain cycle.
    do_reset(4'h0);
    chk("none_ready", data_in_ready, 0);
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    chk("none_drain", flush_done, 0);
    tick();
    chk("none_done", flush_done, 1);
    tick();
    chk("none_done_end", flush_done, 0);
    do_reset(4'hF);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
